// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared combinational ALU.
// One operation in flight: IDLE grants, EXEC samples the ALU, RESP holds the result.
module alu_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic             id_q, id_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d;
    logic             rid_q, rid_d;
    logic             gnt;
    logic             rdy0, rdy1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            id_q    <= 1'b0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            rid_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            id_q    <= id_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            rid_q   <= rid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        id_d    = id_q;
        res_d   = res_q;
        zero_d  = zero_q;
        rid_d   = rid_q;
        gnt     = 1'b0;
        rdy0    = 1'b0;
        rdy1    = 1'b0;
        unique case (state_q)
            IDLE: begin
                // On contention the requester not served last wins
                if (req0_valid && req1_valid) begin
                    gnt = ~last_q;
                end else begin
                    gnt = req1_valid;
                end
                if (req0_valid || req1_valid) begin
                    rdy0    = ~gnt;
                    rdy1    = gnt;
                    a_d     = gnt ? req1_a  : req0_a;
                    b_d     = gnt ? req1_b  : req0_b;
                    op_d    = gnt ? req1_op : req0_op;
                    id_d    = gnt;
                    last_d  = gnt;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                res_d   = alu_result;
                zero_d  = alu_zero;
                rid_d   = id_q;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Readies are forced low while reset is held, even with requests pending
    assign req0_ready  = rst_n & rdy0;
    assign req1_ready  = rst_n & rdy1;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_control = op_q;
    assign rsp_valid   = (state_q == RESP);
    assign rsp_id      = rid_q;
    assign rsp_result  = res_q;
    assign rsp_zero    = zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural shared ALU.
// Expected responses are queued at request handshake and compared at response handshake.
module tb_alu_arbiter;

    localparam int W = 16;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   op;
    } req_t;

    typedef struct {
        logic         id;
        logic [W-1:0] res;
        logic         zero;
        logic [2:0]   op;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid = 1'b0;
    logic         req0_ready;
    logic [W-1:0] req0_a = '0;
    logic [W-1:0] req0_b = '0;
    logic [2:0]   req0_op = '0;
    logic         req1_valid = 1'b0;
    logic         req1_ready;
    logic [W-1:0] req1_a = '0;
    logic [W-1:0] req1_b = '0;
    logic [2:0]   req1_op = '0;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [2:0]   alu_control;
    logic [W-1:0] alu_result;
    logic         alu_zero;
    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [W-1:0] rsp_result;
    logic         rsp_zero;

    int n_chk = 0;
    int n_err = 0;

    req_t q0[$];
    req_t q1[$];
    exp_t exp_q[$];
    logic glog[$];

    int           cyc = 0;
    int           acc_cyc = 0;
    int           acc_cnt = 0;
    logic         last_m = 1'b1;
    logic         hs0 = 1'b0;
    logic         hs1 = 1'b0;
    logic         prev_valid = 1'b0;
    logic         hold = 1'b0;
    logic [W-1:0] h_res;
    logic         h_id;
    logic         h_zero;
    logic [W-1:0] last_res = '0;
    logic         last_id = 1'b0;
    logic         last_zero = 1'b0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_op     (req0_op),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_op     (req1_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_control (alu_control),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_result  (rsp_result),
        .rsp_zero    (rsp_zero)
    );

    function automatic logic [W-1:0] alu_fn(input logic [2:0] op,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b100:  return a ^ b;
            default: return a + b;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_control, alu_a, alu_b);
    assign alu_zero   = (alu_result == '0);

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     tag, got, want, $time);
        end
    endtask

    function automatic exp_t mk_exp(input logic id, input req_t r);
        exp_t e;
        e.id   = id;
        e.op   = r.op;
        e.res  = alu_fn(r.op, r.a, r.b);
        e.zero = (e.res == '0);
        return e;
    endfunction

    // Monitor at negedge, requester drivers just after posedge
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                exp_q.delete();
                last_m     = 1'b1;
                hs0        = 1'b0;
                hs1        = 1'b0;
                prev_valid = 1'b0;
                hold       = 1'b0;
            end else begin
                hs0 = req0_valid & req0_ready;
                hs1 = req1_valid & req1_ready;
                if (hs0 || hs1) begin
                    logic eg;
                    req_t r;
                    eg = (req0_valid && req1_valid) ? ~last_m : req1_valid;
                    chk("one_grant", {31'd0, hs0 & hs1}, 32'd0);
                    chk("grant", {31'd0, hs1}, {31'd0, eg});
                    r = hs1 ? q1[0] : q0[0];
                    exp_q.push_back(mk_exp(hs1, r));
                    glog.push_back(hs1);
                    last_m  = hs1;
                    acc_cyc = cyc;
                    acc_cnt++;
                end
                if (rsp_valid) begin
                    chk("rdy_in_resp", {30'd0, req0_ready, req1_ready}, 32'd0);
                    if (!prev_valid) chk("latency", cyc - acc_cyc, 2);
                    if (hold) begin
                        chk("hold_res", rsp_result, h_res);
                        chk("hold_id", {31'd0, rsp_id}, {31'd0, h_id});
                        chk("hold_zero", {31'd0, rsp_zero}, {31'd0, h_zero});
                    end
                    if (exp_q.size() == 0) begin
                        chk("spurious_rsp", 1, 0);
                    end else begin
                        chk("alu_ctl", alu_control, exp_q[0].op);
                        if (rsp_ready) begin
                            chk("rsp_id", {31'd0, rsp_id}, {31'd0, exp_q[0].id});
                            chk("rsp_res", rsp_result, exp_q[0].res);
                            chk("rsp_zero", {31'd0, rsp_zero},
                                {31'd0, exp_q[0].zero});
                            last_res  = rsp_result;
                            last_id   = rsp_id;
                            last_zero = rsp_zero;
                            void'(exp_q.pop_front());
                        end
                    end
                    hold   = !rsp_ready;
                    h_res  = rsp_result;
                    h_id   = rsp_id;
                    h_zero = rsp_zero;
                end else begin
                    hold = 1'b0;
                end
                prev_valid = rsp_valid;
            end
            @(posedge clk);
            #1;
            if (hs0) void'(q0.pop_front());
            if (hs1) void'(q1.pop_front());
            hs0 = 1'b0;
            hs1 = 1'b0;
            if (q0.size() > 0) begin
                req0_valid = 1'b1;
                req0_a     = q0[0].a;
                req0_b     = q0[0].b;
                req0_op    = q0[0].op;
            end else begin
                req0_valid = 1'b0;
            end
            if (q1.size() > 0) begin
                req1_valid = 1'b1;
                req1_a     = q1[0].a;
                req1_b     = q1[0].b;
                req1_op    = q1[0].op;
            end else begin
                req1_valid = 1'b0;
            end
        end
    end

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(posedge clk);
            #2;
            if (q0.size() == 0 && q1.size() == 0 && exp_q.size() == 0 &&
                !rsp_valid && !req0_valid && !req1_valid)
                done = 1;
        end
        if (!done) chk("idle_timeout", 1, 0);
    endtask

    task automatic wait_rsp();
        bit done = 0;
        for (int i = 0; i < 30 && !done; i++) begin
            @(posedge clk);
            #2;
            if (rsp_valid) done = 1;
        end
        if (!done) chk("rsp_timeout", 1, 0);
    endtask

    initial begin
        int n;
        int cnt;
        bit seen;
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        #1;
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
        chk("rst_ready", {30'd0, req0_ready, req1_ready}, 0);
        chk("rst_alu", {alu_control, alu_a, 13'd0}, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_rsp", {15'd0, rsp_id, rsp_zero, rsp_result}, 0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        // Single add
        q0.push_back('{16'd5, 16'd3, 3'b000});
        wait_idle();
        chk("single_res", last_res, 8);
        chk("single_id", {31'd0, last_id}, 0);
        chk("single_zero", {31'd0, last_zero}, 0);

        // Contention straight out of reset
        @(posedge clk);
        #3 rst_n = 1'b0;
        q0.push_back('{16'd7, 16'd7, 3'b001});
        q1.push_back('{16'h00F0, 16'h0F00, 3'b011});
        repeat (2) @(posedge clk);
        #3;
        chk("rst_ready_busy", {30'd0, req0_ready, req1_ready}, 0);
        glog.delete();
        rst_n = 1'b1;
        wait_idle();
        chk("cont_n", glog.size(), 2);
        if (glog.size() == 2) begin
            chk("cont_first", {31'd0, glog[0]}, 0);
            chk("cont_second", {31'd0, glog[1]}, 1);
        end
        chk("cont_res", last_res, 16'h0FF0);
        chk("cont_id", {31'd0, last_id}, 1);

        // Fairness under continuous contention
        glog.delete();
        for (int i = 0; i < 3; i++) begin
            q0.push_back('{W'(i + 1), W'(i), 3'b010});
            q1.push_back('{W'(i * 3), W'(5), 3'b100});
        end
        wait_idle();
        chk("fair_n", glog.size(), 6);
        for (int i = 0; i < glog.size(); i++)
            chk("fair_order", {31'd0, glog[i]}, i % 2);

        // Backpressure with a second requester waiting
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        q0.push_back('{16'h1234, 16'h0F0F, 3'b100});
        q1.push_back('{16'd10, 16'd20, 3'b000});
        wait_rsp();
        n = acc_cnt;
        repeat (5) @(posedge clk);
        #2;
        chk("bp_no_accept", acc_cnt, n);
        chk("bp_valid", {31'd0, rsp_valid}, 1);
        rsp_ready = 1'b1;
        wait_idle();

        // Reset during EXEC
        n = acc_cnt;
        q0.push_back('{16'd9, 16'd1, 3'b001});
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            #2;
            if (acc_cnt != n) seen = 1;
        end
        chk("exec_seen", {31'd0, seen}, 1);
        chk("exec_a", alu_a, 9);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_alu", {alu_control, alu_a}, 0);
        chk("mid_rst_b", alu_b, 0);
        chk("mid_rst_rsp", {15'd0, rsp_valid, rsp_id, rsp_result}, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        cnt = 0;
        repeat (10) begin
            @(posedge clk);
            #2;
            if (rsp_valid) cnt++;
        end
        chk("no_rsp_after_rst", cnt, 0);

        // Undefined function code passes through
        q1.push_back('{16'd2, 16'd4, 3'b111});
        wait_rsp();
        chk("undef_ctl", alu_control, 3'b111);
        chk("undef_res", rsp_result, 6);
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
